uart_rx: RTL and testbench
==========================

# uart_rx

Memory-mapped UART receiver, 8N1, with a receive FIFO and a level interrupt. It is the receive counterpart to the existing transmit-only `uart` device. It sits as a device on the system bus beside `uart`, and its line input comes from the board RX pin. Software polls STATUS or takes `rx_irq_o`, then drains bytes by reading RXDATA.

## Interface
- `ClockFrequency`, 50_000_000: system clock in Hz.
- `BaudRate`, 115_200: line rate. `ClksPerBit = ClockFrequency / BaudRate` (integer division, ≥ 4). `HalfBit = ClksPerBit / 2`.
- `RxFifoDepth`, 16: FIFO entries; must be a power of two, ≥ 2.

Ports:
- `clk_i`  in  1  system clock; the only clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `device_req_i`  in  1  bus request; single-cycle, always accepted.
- `device_addr_i`  in  32  byte address; only `[3:2]` is decoded.
- `device_we_i`  in  1  write enable.
- `device_be_i`  in  4  byte enables.
- `device_wdata_i`  in  32  write data.
- `device_rvalid_o`  out  1  response valid, one cycle after `req`.
- `device_rdata_o`  out  32  read data; 0 for writes and unmapped offsets.
- `uart_rx_i`  in  1  asynchronous serial line, idle high.
- `rx_irq_o`  out  1  registered level interrupt: `irq_en & !empty`.

## Operation
- `uart_rx_i` passes through a 2-flop synchronizer; the synchronizer resets to 1.
- The FSM uses a bit counter and a baud counter.
  - IDLE: a falling edge (previous synced sample 1, current 0) → START, baud counter cleared.
  - START: after `HalfBit` clocks, sample the line. If low → DATA, bit index 0. If high → IDLE (glitch rejected, nothing recorded).
  - DATA: every `ClksPerBit` clocks, sample one bit into the shift register, LSB first. After bit 7 → STOP.
  - STOP: after `ClksPerBit` clocks, sample the line.
    - High: push the byte. If the FIFO is full and not popped that cycle, drop the byte and set `overflow`.
    - Low: discard the byte and set `frame_err`.
    - Either way → IDLE. Because IDLE needs a falling edge, a held-low break is not re-detected.
- Registers, selected by `addr[3:2]`:
  - 0 RXDATA (read-only): `rdata[7:0]` is the FIFO head and the read pops it. A read when empty returns 0 with no pop. Writes are ignored.
  - 1 STATUS: `[0]` not_empty, `[1]` full, `[2]` overflow, `[3]` frame_err, `[15:8]` fill level. Writing with `be[0]` set is W1C on bits 2 and 3.
  - 2 CTRL: `[0]` irq_en, read/write on `be[0]`, reset 0.
  - 3: reads 0, writes ignored.
- Simultaneous events:
  - Push and pop in the same cycle both take effect; push is accepted even when full.
  - Set and W1C of a sticky bit in the same cycle: set wins.
- Reset values: FSM IDLE, FIFO empty, sticky bits 0, `irq_en` 0, `device_rvalid_o` 0, `device_rdata_o` 0, `rx_irq_o` 0. Reset asserted mid-frame abandons the frame with no push and no error.

## Timing
- Bus:
  - `device_rvalid_o` and `device_rdata_o` are registered, one cycle after `req`.
  - The pop takes effect at the same edge as the registered rdata.
  - A STATUS read issued in the cycle after a pop reflects the pop.
- Receive latency, from the first synced low: `HalfBit + 9*ClksPerBit` clocks to the stop sample.
  - The byte is visible in STATUS and RXDATA the next cycle.
  - `rx_irq_o` rises one cycle after that.
- Synchronizer adds 2 cycles between pin and FSM.
- Sampling point is mid-bit. Tolerated baud mismatch is about ±4%.

## Structure
- Shared package `uart_pkg`:
  - register offset constants (`UART_RX_DATA`, `UART_RX_STATUS`, `UART_RX_CTRL`);
  - STATUS bit-position constants;
  - the FSM state enum `uart_rx_state_e`.
- Sub-module `uart_rx_fifo`:
  - synchronous FIFO, parameterized width and depth;
  - ports: push, pop, wdata, rdata, empty, full, level;
  - pointers one bit wider than the index, for full/empty detection.
- The top level holds the synchronizer, FSM, register file and IRQ.

## Test plan
Parameters for all scenarios: `ClockFrequency=1_000_000`, `BaudRate=100_000` (`ClksPerBit=10`).

1. Send 0xA5 with a valid stop bit. STATUS then reads 0x0101. The next RXDATA read returns 0xA5, after which STATUS reads 0x0000.
2. Set CTRL=1, then send 0x3C. `rx_irq_o` rises exactly `5+90+2+2` cycles after the pin falls. It stays high until the RXDATA pop, and falls the cycle after.
3. Send 17 bytes 0x00..0x10 without reading. STATUS reads `level=16`, full=1, overflow=1. The reads return 0x00..0x0F in order; 0x10 is lost. Writing 0x4 to STATUS clears overflow.
4. Send 0x55 with the stop bit driven low. No push occurs and frame_err=1. Hold the line low for 50 cycles, then high: no further frame and no push. Writing 0x8 to STATUS clears frame_err.
5. Pulse the line low for 3 cycles only. The FSM returns to IDLE, no push, no error bits set.
6. Assert `rst_ni` low during bit 4 of a frame. All outputs return to reset values immediately and the FIFO is empty. The next clean frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART devices: register offsets, STATUS bit
// positions and the receiver FSM state type.
package uart_pkg;

  localparam logic [1:0] UART_RX_DATA   = 2'd0;
  localparam logic [1:0] UART_RX_STATUS = 2'd1;
  localparam logic [1:0] UART_RX_CTRL   = 2'd2;

  localparam int UART_RX_STATUS_NOT_EMPTY = 0;
  localparam int UART_RX_STATUS_FULL      = 1;
  localparam int UART_RX_STATUS_OVERFLOW  = 2;
  localparam int UART_RX_STATUS_FRAME_ERR = 3;
  localparam int UART_RX_STATUS_LEVEL_LSB = 8;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO with pointers one bit wider than the index so that full
// and empty are distinguishable; the head is read combinationally.
module uart_rx_fifo #(
  parameter int Width = 8,
  parameter int Depth = 16,
  localparam int AddrW  = $clog2(Depth),
  localparam int LevelW = AddrW + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push,
  input  logic              pop,
  input  logic [Width-1:0]  wdata,
  output logic [Width-1:0]  rdata,
  output logic              empty,
  output logic              full,
  output logic [LevelW-1:0] level
);

  logic [Width-1:0]  mem_reg [Depth];
  logic [LevelW-1:0] wr_ptr_reg;
  logic [LevelW-1:0] rd_ptr_reg;
  logic              push_en;
  logic              pop_en;

  assign level = wr_ptr_reg - rd_ptr_reg;
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AddrW-1:0] == rd_ptr_reg[AddrW-1:0]) &&
                 (wr_ptr_reg[AddrW] != rd_ptr_reg[AddrW]);

  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // still accepted then.
  assign push_en = push && (!full || pop);
  assign pop_en  = pop && !empty;

  assign rdata = mem_reg[rd_ptr_reg[AddrW-1:0]];

  always_ff @(posedge clk_i) begin
    if (push_en) begin
      mem_reg[wr_ptr_reg[AddrW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_en)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Memory-mapped 8N1 UART receiver: line synchronizer, receive FSM, FIFO,
// STATUS/CTRL registers and a registered level interrupt.
module uart_rx
  import uart_pkg::*;
#(
  parameter int ClockFrequency = 50_000_000,
  parameter int BaudRate       = 115_200,
  parameter int RxFifoDepth    = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        device_req_i,
  input  logic [31:0] device_addr_i,
  input  logic        device_we_i,
  input  logic [3:0]  device_be_i,
  input  logic [31:0] device_wdata_i,
  output logic        device_rvalid_o,
  output logic [31:0] device_rdata_o,
  input  logic        uart_rx_i,
  output logic        rx_irq_o
);

  localparam int ClksPerBit = ClockFrequency / BaudRate;
  localparam int HalfBit    = ClksPerBit / 2;
  localparam int CntW       = $clog2(ClksPerBit);
  localparam int LevelW     = $clog2(RxFifoDepth) + 1;
  localparam logic [CntW-1:0] BitEnd  = CntW'(ClksPerBit - 1);
  localparam logic [CntW-1:0] HalfEnd = CntW'(HalfBit - 1);

  logic [1:0]      sync_reg;
  logic            rx_sync;
  logic            rx_prev_reg;

  uart_rx_state_e  state_reg, state_next;
  logic [CntW-1:0] baud_cnt_reg, baud_cnt_next;
  logic [2:0]      bit_idx_reg, bit_idx_next;
  logic [7:0]      shift_reg, shift_next;
  logic            push_req;
  logic            frame_err_set;

  logic            fifo_pop;
  logic [7:0]      fifo_rdata;
  logic            fifo_empty;
  logic            fifo_full;
  logic [LevelW-1:0] fifo_level;

  logic            overflow_reg, frame_err_reg, irq_en_reg, irq_reg;
  logic            overflow_set;
  logic            rd_req, wr_req, status_w1c, ctrl_wr;
  logic [31:0]     read_data;
  logic            rvalid_reg;
  logic [31:0]     rdata_reg;

  logic            unused_bits;
  assign unused_bits = ^{device_addr_i[31:4], device_addr_i[1:0], device_be_i[3:1],
                         device_wdata_i[31:4], device_wdata_i[1]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_reg    <= 2'b11;
      rx_prev_reg <= 1'b1;
    end else begin
      sync_reg    <= {sync_reg[0], uart_rx_i};
      rx_prev_reg <= rx_sync;
    end
  end
  assign rx_sync = sync_reg[1];

  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_cnt_reg;
    bit_idx_next  = bit_idx_reg;
    shift_next    = shift_reg;
    push_req      = 1'b0;
    frame_err_set = 1'b0;
    case (state_reg)
      RX_IDLE: begin
        // Only a real 1->0 transition starts a frame; a held-low line never does.
        if (rx_prev_reg && !rx_sync) begin
          state_next    = RX_START;
          baud_cnt_next = '0;
        end
      end
      RX_START: begin
        if (baud_cnt_reg == HalfEnd) begin
          baud_cnt_next = '0;
          bit_idx_next  = 3'd0;
          state_next    = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end
      RX_DATA: begin
        if (baud_cnt_reg == BitEnd) begin
          baud_cnt_next = '0;
          shift_next    = {rx_sync, shift_reg[7:1]};
          if (bit_idx_reg == 3'd7) begin
            state_next = RX_STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end
      RX_STOP: begin
        if (baud_cnt_reg == BitEnd) begin
          baud_cnt_next = '0;
          state_next    = RX_IDLE;
          push_req      = rx_sync;
          frame_err_set = !rx_sync;
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end
      default: state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= RX_IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_idx_reg  <= bit_idx_next;
      shift_reg    <= shift_next;
    end
  end

  assign rd_req     = device_req_i && !device_we_i;
  assign wr_req     = device_req_i && device_we_i;
  assign fifo_pop   = rd_req && (device_addr_i[3:2] == UART_RX_DATA);
  assign status_w1c = wr_req && (device_addr_i[3:2] == UART_RX_STATUS) && device_be_i[0];
  assign ctrl_wr    = wr_req && (device_addr_i[3:2] == UART_RX_CTRL) && device_be_i[0];
  assign overflow_set = push_req && fifo_full && !fifo_pop;

  uart_rx_fifo #(
    .Width (8),
    .Depth (RxFifoDepth)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (push_req),
    .pop    (fifo_pop),
    .wdata  (shift_reg),
    .rdata  (fifo_rdata),
    .empty  (fifo_empty),
    .full   (fifo_full),
    .level  (fifo_level)
  );

  always_comb begin
    read_data = '0;
    case (device_addr_i[3:2])
      UART_RX_DATA: begin
        if (!fifo_empty) read_data[7:0] = fifo_rdata;
      end
      UART_RX_STATUS: begin
        read_data[UART_RX_STATUS_NOT_EMPTY] = !fifo_empty;
        read_data[UART_RX_STATUS_FULL]      = fifo_full;
        read_data[UART_RX_STATUS_OVERFLOW]  = overflow_reg;
        read_data[UART_RX_STATUS_FRAME_ERR] = frame_err_reg;
        read_data[UART_RX_STATUS_LEVEL_LSB +: 8] = 8'(fifo_level);
      end
      UART_RX_CTRL: read_data[0] = irq_en_reg;
      default: read_data = '0;
    endcase
  end

  // Sticky bits: a set in the same cycle as a W1C wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      irq_en_reg    <= 1'b0;
      irq_reg       <= 1'b0;
      rvalid_reg    <= 1'b0;
      rdata_reg     <= '0;
    end else begin
      overflow_reg  <= overflow_set ||
                       (overflow_reg && !(status_w1c && device_wdata_i[2]));
      frame_err_reg <= frame_err_set ||
                       (frame_err_reg && !(status_w1c && device_wdata_i[3]));
      if (ctrl_wr) irq_en_reg <= device_wdata_i[0];
      irq_reg       <= irq_en_reg && !fifo_empty;
      rvalid_reg    <= device_req_i;
      rdata_reg     <= rd_req ? read_data : '0;
    end
  end

  assign device_rvalid_o = rvalid_reg;
  assign device_rdata_o  = rdata_reg;
  assign rx_irq_o        = irq_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 10 clocks per bit: reception, irq timing,
// overflow, framing error, glitch rejection and mid-frame reset.
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        pin;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_rx #(
    .ClockFrequency (1_000_000),
    .BaudRate       (100_000),
    .RxFifoDepth    (16)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .device_req_i    (req),
    .device_addr_i   (addr),
    .device_we_i     (we),
    .device_be_i     (be),
    .device_wdata_i  (wdata),
    .device_rvalid_o (rvalid),
    .device_rdata_o  (rdata),
    .uart_rx_i       (pin),
    .rx_irq_o        (irq)
  );

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic v);
    req = 1'b1; we = 1'b0; addr = a; be = 4'hF; wdata = '0;
    @(negedge clk);
    d = rdata; v = rvalid; req = 1'b0;
    $display("rd   addr=%h data=%h valid=%b", a, d, v);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    req = 1'b1; we = 1'b1; addr = a; be = b; wdata = d;
    @(negedge clk);
    req = 1'b0; we = 1'b0;
    $display("wr   addr=%h data=%h be=%h", a, d, b);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop);
    logic [9:0] frame;
    frame = {stop, data, 1'b0};
    for (int s = 0; s < 10; s++) begin
      pin = frame[s];
      repeat (10) @(negedge clk);
    end
    $display("tx   byte=%h stop=%b", data, stop);
  endtask

  task automatic test_reset;
    logic [31:0] d;
    logic v;
    n_vec++; if (rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid got=%b exp=0", rvalid); end
    n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got=%b exp=0", irq); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    bus_read(32'h4, d, v);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_status got=%h exp=00000000", d); end
    bus_read(32'h8, d, v);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_ctrl got=%h exp=00000000", d); end
  endtask

  task automatic test_basic;
    logic [31:0] d;
    logic v;
    send_frame(8'hA5, 1'b1);
    bus_read(32'h4, d, v);
    n_vec++; if (d !== 32'h0101) begin n_err++; $display("FAIL basic_status got=%h exp=00000101", d); end
    n_vec++; if (v !== 1'b1) begin n_err++; $display("FAIL basic_rvalid got=%b exp=1", v); end
    bus_read(32'h0, d, v);
    n_vec++; if (d !== 32'hA5) begin n_err++; $display("FAIL basic_rxdata got=%h exp=000000a5", d); end
    bus_read(32'h4, d, v);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL basic_status_after got=%h exp=00000000", d); end
    bus_write(32'h0, 32'hFF, 4'hF);
    bus_read(32'h4, d, v);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL basic_rxdata_write got=%h exp=00000000", d); end
  endtask

  task automatic test_irq;
    logic [31:0] d;
    logic v;
    logic [9:0] frame;
    int rise;
    bus_write(32'h8, 32'h1, 4'h1);
    frame = {1'b1, 8'h3C, 1'b0};
    rise = -1;
    pin = 1'b0;
    for (int k = 1; k <= 110; k++) begin
      @(negedge clk);
      if (irq && rise < 0) rise = k;
      pin = (k < 100) ? frame[k/10] : 1'b1;
    end
    $display("tx   byte=3c irq_rise=%0d", rise);
    n_vec++; if (rise !== 99) begin n_err++; $display("FAIL irq_latency got=%0d exp=99", rise); end
    bus_read(32'h0, d, v);
    n_vec++; if (d !== 32'h3C) begin n_err++; $display("FAIL irq_rxdata got=%h exp=0000003c", d); end
    n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_at_pop got=%b exp=1", irq); end
    @(negedge clk);
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_after_pop got=%b exp=0", irq); end
  endtask

  task automatic test_overflow;
    logic [31:0] d;
    logic v;
    for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1);
    bus_read(32'h4, d, v);
    n_vec++; if (d !== 32'h1007) begin n_err++; $display("FAIL ovf_status got=%h exp=00001007", d); end
    for (int i = 0; i < 16; i++) begin
      bus_read(32'h0, d, v);
      n_vec++; if (d !== 32'(i)) begin n_err++; $display("FAIL ovf_read%0d got=%h exp=%h", i, d, 32'(i)); end
    end
    bus_read(32'h0, d, v);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL ovf_empty_read got=%h exp=00000000", d); end
    bus_read(32'h4, d, v);
    n_vec++; if (d !== 32'h0004) begin n_err++; $display("FAIL ovf_status_drained got=%h exp=00000004", d); end
    bus_write(32'h4, 32'h4, 4'h1);
    bus_read(32'h4, d, v);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL ovf_w1c got=%h exp=00000000", d); end
  endtask

  task automatic test_frame_err;
    logic [31:0] d;
    logic v;
    send_frame(8'h55, 1'b0);
    bus_read(32'h4, d, v);
    n_vec++; if (d !== 32'h0008) begin n_err++; $display("FAIL ferr_status got=%h exp=00000008", d); end
    repeat (50) @(negedge clk);
    pin = 1'b1;
    repeat (150) @(negedge clk);
    bus_read(32'h4, d, v);
    n_vec++; if (d !== 32'h0008) begin n_err++; $display("FAIL ferr_break got=%h exp=00000008", d); end
    bus_write(32'h4, 32'h8, 4'h1);
    bus_read(32'h4, d, v);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL ferr_w1c got=%h exp=00000000", d); end
  endtask

  task automatic test_glitch;
    logic [31:0] d;
    logic v;
    pin = 1'b0;
    repeat (3) @(negedge clk);
    pin = 1'b1;
    repeat (150) @(negedge clk);
    $display("tx   glitch 3 cycles");
    bus_read(32'h4, d, v);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL glitch_status got=%h exp=00000000", d); end
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL glitch_irq got=%b exp=0", irq); end
  endtask

  task automatic test_reset_midframe;
    logic [31:0] d;
    logic v;
    logic [9:0] frame;
    send_frame(8'h11, 1'b1);
    frame = {1'b1, 8'h5A, 1'b0};
    for (int k = 0; k < 55; k++) begin
      pin = frame[k/10];
      if (k == 54) begin
        req = 1'b1; we = 1'b0; addr = 32'h4;
      end
      @(negedge clk);
    end
    n_vec++; if (rdata !== 32'h0101) begin n_err++; $display("FAIL rst_pre_rdata got=%h exp=00000101", rdata); end
    n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL rst_pre_irq got=%b exp=1", irq); end
    rst_n = 1'b0;
    req = 1'b0;
    #1;
    $display("rst  asserted during bit 4");
    n_vec++; if (rvalid !== 1'b0) begin n_err++; $display("FAIL rst_rvalid got=%b exp=0", rvalid); end
    n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL rst_irq got=%b exp=0", irq); end
    pin = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (150) @(negedge clk);
    bus_read(32'h4, d, v);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL rst_status got=%h exp=00000000", d); end
    bus_read(32'h8, d, v);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL rst_ctrl got=%h exp=00000000", d); end
    send_frame(8'h81, 1'b1);
    bus_read(32'h4, d, v);
    n_vec++; if (d !== 32'h0101) begin n_err++; $display("FAIL rst_next_status got=%h exp=00000101", d); end
    bus_read(32'h0, d, v);
    n_vec++; if (d !== 32'h81) begin n_err++; $display("FAIL rst_next_rxdata got=%h exp=00000081", d); end
  endtask

  initial begin
    rst_n = 1'b0;
    pin   = 1'b1;
    req   = 1'b0;
    we    = 1'b0;
    addr  = '0;
    be    = '0;
    wdata = '0;
    repeat (3) @(negedge clk);
    test_reset;
    test_basic;
    test_irq;
    test_overflow;
    test_frame_err;
    test_glitch;
    test_reset_midframe;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
